rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Parametrised N-requester arbiter with registered one-hot grant. Successor to the combinational fixed-priority arbiter netlists.
- Adds round-robin fairness, a run-time fixed-priority mode, grant hold across multi-cycle ownership, a bounded hold time with preemption, and a lock override.
- Sits between N bus/resource requesters and a single shared resource.

Parameters:
- N, 4, number of requesters (2..32).
- HOLD_MAX, 8, maximum consecutive grant cycles before preemption when others are waiting (1..255).
- ID_W, $clog2(N), width of grant_id (derived, not overridable).
- CNT_W, $clog2(HOLD_MAX+1), width of hold counter (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector; bit i high = requester i wants the resource.
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- lock  in  1  when high, suppresses HOLD_MAX preemption of the current owner.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  high when any grant bit is set.
- grant_id  out  ID_W  binary index of the owner; 0 when idle.
- hold_cnt  out  CNT_W  cycles the current owner has held the grant, saturating.

Behaviour:
- Reset: async on rst_n low. Outputs on reset: grant=0, grant_valid=0, grant_id=0, hold_cnt=0, state=IDLE, rr pointer ptr=0. Outputs are glitch-free once rst_n is released.
- FSM states: IDLE, OWNED.
- IDLE:
  - If req != 0, pick winner W and go to OWNED.
  - Next-cycle outputs: grant=1<<W, grant_id=W, hold_cnt=1.
  - Latency from req to grant is exactly 1 cycle.
- Winner pick:
  - mode=0: first set bit of req at index >= ptr, wrapping to index 0 (masked/unmasked double search).
  - mode=1: lowest set bit, ptr ignored.
  - On every new grant, ptr <= (W+1) mod N, in both modes.
- OWNED, owner O:
  - Release when req[O]=0.
  - Preempt when hold_cnt==HOLD_MAX && lock==0 && (req & ~(1<<O)) != 0.
  - On release or preempt: if other requests exist, arbitrate among req with bit O masked and grant the winner on the next edge. There is no idle bubble, and the handover is a single clock edge. Otherwise go to IDLE: grant=0 next cycle.
  - Otherwise keep O; hold_cnt increments, saturating at HOLD_MAX.
  - A sole requester is never preempted and keeps the grant indefinitely.
- Simultaneous release by O and a new request by O (req[O] drops then rises): O is treated as a fresh requester and competes normally.
- A mode change mid-ownership does not disturb the current owner. It applies at the next arbitration.
- A lock that rises after hold_cnt already equals HOLD_MAX cancels the pending preemption in that cycle.
- grant is always one-hot or zero. grant_id and grant_valid are consistent with grant in the same cycle.
- Reset asserted mid-ownership: grant drops immediately (async), and ptr returns to 0.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_t {IDLE, OWNED};
  - function onehot2bin;
  - localparam helpers for ID_W and CNT_W.
- Sub-module arb_pick (combinational):
  - inputs: req[N], ptr[ID_W], mode;
  - outputs: found, win_id[ID_W].
  - It is instantiated once; the owner mask is applied to its req input in OWNED.
- The top holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset then req=4'b0110, mode=0: grant=4'b0010 one cycle later, grant_id=1, ptr=2. Drop req[1]: next cycle grant=4'b0100, no bubble.
- Round-robin fairness, N=4, req=4'b1111 held, HOLD_MAX=1, lock=0: the grant sequence is 0001,0010,0100,1000,0001 on consecutive cycles, each owner held 1 cycle.
- Preemption, HOLD_MAX=8: req=4'b0001 alone for 20 cycles gives grant held and hold_cnt saturated at 8. Raise req[2]: grant=4'b0100 on the next edge after the request is seen.
- Lock, HOLD_MAX=8: req=4'b0011 with lock=1 from the start: grant[0] is held for 30 cycles. Drop lock: grant moves to 4'b0010 one cycle later.
- Fixed mode: mode=1, ptr=3, req=4'b1010: grant=4'b0010. Then set mode=0 and release the owner: the next winner is index 3.
- Async reset mid-OWNED: pull rst_n low between clock edges. grant=0, grant_valid=0 and hold_cnt=0 immediately, with no clock edge. After release with req=4'b1000, grant=4'b1000 and ptr wraps to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin lock arbiter.
// Imported by the winner picker and the arbiter top.
package arb_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned hold_max);
        return $clog2(hold_max + 1);
    endfunction

    // Index of the set bit of a one-hot vector; zero when the vector is empty.
    function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] oh);
        logic [4:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) bin = bin | 5'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: round-robin from ptr with wrap,
// or lowest index when mode is high.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = calc_id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic            found,
    output logic [ID_W-1:0] win_id
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] thermo;
    logic [N-1:0] masked;
    logic [N-1:0] pick_vec;
    logic [N-1:0] lowest;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        // Bits at or above ptr; when none of those request, fall back to the full vector.
        thermo   = ~((ONE << ptr) - ONE);
        masked   = req & thermo;
        pick_vec = (!mode && (masked != '0)) ? masked : req;
        lowest   = pick_vec & (~pick_vec + ONE);
        found    = |req;
        win_id   = ID_W'(onehot2bin(MAX_N'(lowest)));
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-requester arbiter with registered one-hot grant, round-robin or fixed
// priority, multi-cycle ownership, bounded hold with preemption and lock.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8,
    localparam int unsigned ID_W    = calc_id_w(N),
    localparam int unsigned CNT_W   = calc_cnt_w(HOLD_MAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             lock,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [N-1:0]     ONE      = N'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    logic [N-1:0]    pick_req;
    logic            found;
    logic [ID_W-1:0] win_id;
    logic            owner_req;
    logic            others;
    logic            preempt;
    logic            rearb;
    logic [ID_W-1:0] next_ptr;

    // grant is zero in IDLE, so masking with it only removes the owner in OWNED.
    assign pick_req  = req & ~grant;
    assign owner_req = |(req & grant);
    assign others    = |pick_req;
    assign preempt   = (hold_cnt == CNT_SAT) && !lock && others;
    assign next_ptr  = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);

    always_comb begin
        rearb = 1'b0;
        unique case (state)
            IDLE:  rearb = 1'b1;
            OWNED: rearb = !owner_req || preempt;
        endcase
    end

    arb_pick #(
        .N (N)
    ) u_pick (
        .req    (pick_req),
        .ptr    (ptr),
        .mode   (mode),
        .found  (found),
        .win_id (win_id)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_cnt    <= '0;
        end else if (rearb) begin
            if (found) begin
                state       <= OWNED;
                ptr         <= next_ptr;
                grant       <= ONE << win_id;
                grant_valid <= 1'b1;
                grant_id    <= win_id;
                hold_cnt    <= CNT_W'(1);
            end else begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
                hold_cnt    <= '0;
            end
        end else if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: one instance with HOLD_MAX=8 and one
// with HOLD_MAX=1 for the round-robin rotation sequence.
module tb_rr_lock_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;
    logic       lock;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] hold_cnt;

    logic [3:0] req_rr;
    logic [3:0] grant_rr;
    logic       grant_valid_rr;
    logic [1:0] grant_id_rr;
    logic [0:0] hold_cnt_rr;

    int n_vec;
    int n_err;

    rr_lock_arbiter #(.N(4), .HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mode        (mode),
        .lock        (lock),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_cnt    (hold_cnt)
    );

    rr_lock_arbiter #(.N(4), .HOLD_MAX(1)) dut_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_rr),
        .mode        (1'b0),
        .lock        (1'b0),
        .grant       (grant_rr),
        .grant_valid (grant_valid_rr),
        .grant_id    (grant_id_rr),
        .hold_cnt    (hold_cnt_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        req    = '0;
        req_rr = '0;
        mode   = 1'b0;
        lock   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({grant, grant_valid, grant_id, hold_cnt} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got grant=%b valid=%b id=%0d hold=%0d, want all zero",
                     grant, grant_valid, grant_id, hold_cnt);
        end
        n_vec++;
        if (dut.ptr !== 2'd0) begin
            n_err++;
            $display("FAIL reset_ptr: got %0d want 0", dut.ptr);
        end
        n_vec++;
        if ({grant_rr, grant_valid_rr, grant_id_rr, hold_cnt_rr} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_outputs_rr: got grant=%b valid=%b want zero", grant_rr, grant_valid_rr);
        end
    endtask

    task automatic test_basic_handover();
        apply_reset();
        req = 4'b0110;
        step();
        n_vec++;
        if ({grant, grant_valid, grant_id, hold_cnt} !== {4'b0010, 1'b1, 2'd1, 4'd1}) begin
            n_err++;
            $display("FAIL first_grant: got grant=%b valid=%b id=%0d hold=%0d, want 0010 1 1 1",
                     grant, grant_valid, grant_id, hold_cnt);
        end
        n_vec++;
        if (dut.ptr !== 2'd2) begin
            n_err++;
            $display("FAIL first_grant_ptr: got %0d want 2", dut.ptr);
        end
        req = 4'b0100;
        step();
        n_vec++;
        if ({grant, grant_id, hold_cnt} !== {4'b0100, 2'd2, 4'd1}) begin
            n_err++;
            $display("FAIL no_bubble_handover: got grant=%b id=%0d hold=%0d, want 0100 2 1",
                     grant, grant_id, hold_cnt);
        end
        req = 4'b0000;
        step();
        n_vec++;
        if ({grant, grant_valid, grant_id, hold_cnt} !== 11'b0) begin
            n_err++;
            $display("FAIL release_to_idle: got grant=%b valid=%b id=%0d hold=%0d, want all zero",
                     grant, grant_valid, grant_id, hold_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req_rr = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            n_vec++;
            if (grant_rr !== exp_seq[k] || hold_cnt_rr !== 1'b1) begin
                n_err++;
                $display("FAIL rr_rotation[%0d]: got grant=%b hold=%0d, want %b 1",
                         k, grant_rr, hold_cnt_rr, exp_seq[k]);
            end
        end
        req_rr = 4'b0000;
        step();
    endtask

    task automatic test_preempt();
        apply_reset();
        req = 4'b0001;
        repeat (20) step();
        n_vec++;
        if ({grant, hold_cnt} !== {4'b0001, 4'd8}) begin
            n_err++;
            $display("FAIL sole_owner_saturate: got grant=%b hold=%0d, want 0001 8", grant, hold_cnt);
        end
        req = 4'b0101;
        step();
        n_vec++;
        if ({grant, grant_id, hold_cnt} !== {4'b0100, 2'd2, 4'd1}) begin
            n_err++;
            $display("FAIL preempt_to_2: got grant=%b id=%0d hold=%0d, want 0100 2 1",
                     grant, grant_id, hold_cnt);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        lock = 1'b1;
        req  = 4'b0011;
        step();
        repeat (29) step();
        n_vec++;
        if ({grant, hold_cnt} !== {4'b0001, 4'd8}) begin
            n_err++;
            $display("FAIL lock_hold_30: got grant=%b hold=%0d, want 0001 8", grant, hold_cnt);
        end
        lock = 1'b0;
        step();
        n_vec++;
        if ({grant, grant_id} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL unlock_preempt: got grant=%b id=%0d, want 0010 1", grant, grant_id);
        end
        // Owner 1 climbs to saturation; lock rising in that cycle cancels the preemption.
        repeat (7) step();
        lock = 1'b1;
        step();
        n_vec++;
        if ({grant, hold_cnt} !== {4'b0010, 4'd8}) begin
            n_err++;
            $display("FAIL late_lock_cancel: got grant=%b hold=%0d, want 0010 8", grant, hold_cnt);
        end
        lock = 1'b0;
        step();
        n_vec++;
        if ({grant, grant_id} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL wrap_after_unlock: got grant=%b id=%0d, want 0001 0", grant, grant_id);
        end
    endtask

    task automatic test_fixed_mode();
        apply_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        n_vec++;
        if (dut.ptr !== 2'd3) begin
            n_err++;
            $display("FAIL fixed_setup_ptr: got %0d want 3", dut.ptr);
        end
        mode = 1'b1;
        req  = 4'b1010;
        step();
        n_vec++;
        if ({grant, grant_id} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL fixed_lowest: got grant=%b id=%0d, want 0010 1", grant, grant_id);
        end
        mode = 1'b0;
        step();
        n_vec++;
        if (grant !== 4'b0010) begin
            n_err++;
            $display("FAIL mode_change_keeps_owner: got grant=%b want 0010", grant);
        end
        req = 4'b1000;
        step();
        n_vec++;
        if ({grant, grant_id} !== {4'b1000, 2'd3}) begin
            n_err++;
            $display("FAIL rr_after_fixed: got grant=%b id=%0d, want 1000 3", grant, grant_id);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0010;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({grant, grant_valid, hold_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got grant=%b valid=%b hold=%0d, want all zero",
                     grant, grant_valid, hold_cnt);
        end
        n_vec++;
        if (dut.ptr !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset_ptr: got %0d want 0", dut.ptr);
        end
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({grant, grant_valid, grant_id} !== {4'b1000, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL post_reset_grant: got grant=%b valid=%b id=%0d, want 1000 1 3",
                     grant, grant_valid, grant_id);
        end
        n_vec++;
        if (dut.ptr !== 2'd0) begin
            n_err++;
            $display("FAIL ptr_wrap: got %0d want 0", dut.ptr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_handover();
        test_round_robin();
        test_preempt();
        test_lock();
        test_fixed_mode();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
